sdram_byte_port: RTL

SDRAM_BYTE_PORT -- requirements
Module: sdram_byte_port

---
 rtl/sdram_bus_if.sv | 31 +++
 rtl/sdram_byte_port.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/sdram_bus_if.sv
// ============================================================================
//  Module   : sdram_bus
//  Brief    : Word-wide request/acknowledge bus between a host port and an
//             SDRAM controller.
//  Revision : 1.0
// ============================================================================
`default_nettype none

interface sdram_bus #(
    parameter int AW = 22
) ();
    logic          req;
    logic          ack;
    logic [AW-1:0] address;
    logic [15:0]   data_write;
    logic [15:0]   data_read;
    logic          we;
    logic [1:0]    wm;

    modport master (
        output req, address, data_write, we, wm,
        input  ack, data_read
    );

    modport slave (
        input  req, address, data_write, we, wm,
        output ack, data_read
    );
endinterface

`default_nettype wire

// File: rtl/sdram_byte_port.sv
// ============================================================================
//  Module   : sdram_byte_port
//  Brief    : Byte-wide host port onto a 16-bit SDRAM request/ack bus.
//             Define SDRAM_BYTE_PORT_CACHE_EN to add a one-word read buffer.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module sdram_byte_port #(
    parameter  int ROW_BITS = 12,
    parameter  int COL_BITS = 8,
    localparam int AW       = ROW_BITS + COL_BITS + 2,
    localparam int BW       = AW + 1
) (
    input  wire logic          clk,
    input  wire logic          reset,
    input  wire logic          rd,
    input  wire logic          wr,
    input  wire logic [BW-1:0] addr,
    input  wire logic [7:0]    wdata,
    input  wire logic          invalidate,
    output logic [7:0]         rdata,
    output logic               rvalid,
    output logic               busy,
    sdram_bus.master           mem
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WAIT_ACK = 2'd1,
        DONE     = 2'd2
    } state_t;

    state_t        r_state;
    logic          r_req;
    logic          r_we;
    logic          r_sel;
    logic          r_rvalid;
    logic          r_busy;
    logic          r_stale;
    logic [AW-1:0] r_addr;
    logic [15:0]   r_wdata;
    logic [1:0]    r_wm;
    logic [7:0]    r_rdata;

    logic [AW-1:0] w_word;
    logic          w_idle;
    logic          w_hit;
    logic          w_start;

    assign w_word = addr[BW-1:1];
    assign w_idle = (r_state == IDLE) && !r_busy;

`ifdef SDRAM_BYTE_PORT_CACHE_EN
    logic          r_buf_valid;
    logic [AW-1:0] r_buf_tag;
    logic [15:0]   r_buf_word;

    assign w_hit = w_idle && rd && !wr && r_buf_valid && (r_buf_tag == w_word);
`else
    logic w_unused_inval;

    assign w_unused_inval = invalidate;
    assign w_hit          = 1'b0;
`endif

    assign w_start = w_idle && (wr || (rd && !w_hit));

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= IDLE;
            r_req    <= 1'b0;
            r_rvalid <= 1'b0;
            r_busy   <= 1'b0;
            r_rdata  <= 8'h00;
            // An access cut off by reset still owes us one ack; swallow it later.
            r_stale  <= (r_stale || (r_state == WAIT_ACK)) && !mem.ack;
        end else begin
            r_req    <= 1'b0;
            r_rvalid <= 1'b0;
            if (mem.ack && r_stale) begin
                r_stale <= 1'b0;
            end
            case (r_state)
                IDLE: begin
                    if (w_start) begin
                        r_state <= WAIT_ACK;
                        r_req   <= 1'b1;
                        r_busy  <= 1'b1;
                        r_addr  <= w_word;
                        r_we    <= wr;
                        r_sel   <= addr[0];
                        r_wm    <= wr ? (addr[0] ? 2'b01 : 2'b10) : 2'b00;
                        if (wr) begin
                            r_wdata <= {wdata, wdata};
                        end
                    end
`ifdef SDRAM_BYTE_PORT_CACHE_EN
                    if (w_hit) begin
                        r_rvalid <= 1'b1;
                        r_rdata  <= addr[0] ? r_buf_word[15:8] : r_buf_word[7:0];
                    end
`endif
                end
                WAIT_ACK: begin
                    if (mem.ack && !r_stale) begin
                        r_state <= DONE;
                        if (!r_we) begin
                            r_rvalid <= 1'b1;
                            r_rdata  <= r_sel ? mem.data_read[15:8] : mem.data_read[7:0];
                        end
                    end
                end
                DONE: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

`ifdef SDRAM_BYTE_PORT_CACHE_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            r_buf_valid <= 1'b0;
        end else begin
            if ((r_state == WAIT_ACK) && mem.ack && !r_stale && !r_we) begin
                r_buf_valid <= 1'b1;
                r_buf_tag   <= r_addr;
                r_buf_word  <= mem.data_read;
            end
            // Write-through: keep the buffered copy coherent with the write.
            if (w_idle && wr && r_buf_valid && (r_buf_tag == w_word)) begin
                if (addr[0]) begin
                    r_buf_word[15:8] <= wdata;
                end else begin
                    r_buf_word[7:0] <= wdata;
                end
            end
            if (invalidate) begin
                r_buf_valid <= 1'b0;
            end
        end
    end
`endif

    assign rdata          = r_rdata;
    assign rvalid         = r_rvalid;
    assign busy           = r_busy;
    assign mem.req        = r_req;
    assign mem.address    = r_addr;
    assign mem.data_write = r_wdata;
    assign mem.we         = r_we;
    assign mem.wm         = r_wm;

endmodule

`default_nettype wire
